// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: registered one-hot and binary grant.
// A hold timer forces rotation when other clients are waiting.
module round_robin_arbiter #(
  parameter int REQUESTERS = 16,
  parameter int INDEX      = 4,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  Clk_I,
  input  logic                  Rst_N_I,
  input  logic [REQUESTERS-1:0] Req_I,
  output logic [REQUESTERS-1:0] Grant_O,
  output logic [INDEX-1:0]      Grant_Idx_O,
  output logic                  Grant_Valid_O
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic [INDEX-1:0]      last_ptr, last_ptr_nxt;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_nxt;
  logic [REQUESTERS-1:0] grant_nxt;
  logic [INDEX-1:0]      idx_nxt;
  logic                  valid_nxt;

  logic [REQUESTERS-1:0] others;
  logic [INDEX-1:0]      win_all, win_oth;
  logic                  cur_req, hold_done;

  // First set bit after ptr, wrapping; ptr itself is examined last.
  function automatic logic [INDEX-1:0] pick(input logic [REQUESTERS-1:0] req,
                                            input logic [INDEX-1:0]      ptr);
    logic [INDEX-1:0] win;
    logic             found;
    int               k;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      k = (int'(ptr) + i) % REQUESTERS;
      if (!found && req[k]) begin
        win   = k[INDEX-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [REQUESTERS-1:0] onehot(input logic [INDEX-1:0] i);
    logic [REQUESTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign others    = Req_I & ~onehot(last_ptr);
  assign cur_req   = Req_I[last_ptr];
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign win_all   = pick(Req_I, last_ptr);
  assign win_oth   = pick(others, last_ptr);

  always_comb begin
    state_nxt    = state;
    last_ptr_nxt = last_ptr;
    hold_cnt_nxt = hold_cnt;
    grant_nxt    = Grant_O;
    idx_nxt      = Grant_Idx_O;
    valid_nxt    = Grant_Valid_O;
    case (state)
      IDLE: begin
        if (|Req_I) begin
          state_nxt    = BUSY;
          last_ptr_nxt = win_all;
          hold_cnt_nxt = '0;
          grant_nxt    = onehot(win_all);
          idx_nxt      = win_all;
          valid_nxt    = 1'b1;
        end
      end
      BUSY: begin
        // A release takes precedence over a simultaneous timeout.
        if (cur_req) begin
          if (hold_done && |others) begin
            last_ptr_nxt = win_oth;
            hold_cnt_nxt = '0;
            grant_nxt    = onehot(win_oth);
            idx_nxt      = win_oth;
          end else if (!hold_done) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end else if (|others) begin
          last_ptr_nxt = win_oth;
          hold_cnt_nxt = '0;
          grant_nxt    = onehot(win_oth);
          idx_nxt      = win_oth;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_I or negedge Rst_N_I) begin
    if (!Rst_N_I) begin
      state         <= IDLE;
      last_ptr      <= INDEX'(REQUESTERS - 1);
      hold_cnt      <= '0;
      Grant_O       <= '0;
      Grant_Idx_O   <= '0;
      Grant_Valid_O <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_ptr      <= last_ptr_nxt;
      hold_cnt      <= hold_cnt_nxt;
      Grant_O       <= grant_nxt;
      Grant_Idx_O   <= idx_nxt;
      Grant_Valid_O <= valid_nxt;
    end
  end

endmodule
